pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed ID/EX latch.
- Carries one pipeline stage's data bundle and control bundle, with a valid/ready handshake and a 2-entry skid buffer.
- Upstream can stall without a combinational ready path.
- Adds flush (branch/jump squash), bubble-safe control output and a stall-cycle counter; instantiated between any two stages (ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 128, width of the data bundle (instr, rs/rt data, sign-ext, branch address, register indices).
- CTRL_W, 16, width of the control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, ...).
- CTRL_BUBBLE, 0, control value driven when the stage holds no valid entry (a NOP: no writes).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  DATA_W  head data.
- out_ctrl  out  CTRL_W  head control; CTRL_BUBBLE when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Assertion takes effect immediately, independent of clk.
- Reset state:
  - state=EMPTY, in_ready=1, out_valid=0.
  - out_data=0, out_ctrl=CTRL_BUBBLE, stall_cnt=0.
  - Main and skid registers cleared to 0 / CTRL_BUBBLE.
- Definitions: push = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
- States: EMPTY (no entries), ONE (main full), TWO (main+skid full). out_valid=1 in ONE and TWO. Head is always main.
- Transitions:
  - EMPTY: push -> ONE, main<=in.
  - ONE:
    - push & ~pop -> TWO, skid<=in.
    - push & pop -> ONE, main<=in.
    - ~push & pop -> EMPTY.
    - else hold.
  - TWO: pop -> ONE, main<=skid. push cannot occur (in_ready=0).
- in_ready register: next value = (next_state != TWO).
- Latency: an entry pushed at edge N is presented at out_* after edge N (1 cycle) when the stage was EMPTY, or when it was ONE and popped in the same cycle. Throughput is 1 entry/cycle with out_ready held high.
- Ordering: strict FIFO; the skid entry is never presented before main.
- Flush (priority over push/pop):
  - next state=EMPTY, in_ready<=1.
  - Input in the flush cycle is discarded.
  - A pop in the same cycle still completes downstream (the head was presented).
  - Data registers need not clear; out_ctrl is forced to CTRL_BUBBLE by out_valid=0.
- Stall counter: increments on each cycle with out_valid & ~out_ready. Saturates at 2^CNT_W-1, no wrap. Cleared only by reset.
- Hold stability: while out_valid & ~out_ready, out_data and out_ctrl must not change.
- Reset mid-operation: all entries lost immediately; outputs reach reset values asynchronously.

Decomposition:
- Shared package pipe_pkg:
  - stage state enum (EMPTY/ONE/TWO).
  - localparam NOP control bundle used as CTRL_BUBBLE.
  - per-stage DATA_W/CTRL_W constants (ID_EX_DATA_W, EX_MEM_DATA_W, ...).
- One natural sub-module: pipe_sat_counter (CNT_W saturating counter with enable), reusable for other stage stall/flush statistics.

Test Plan:
- Reset: rst_n=0 mid-cycle while in state TWO -> out_valid=0, in_ready=1, out_ctrl=CTRL_BUBBLE, stall_cnt=0 immediately, without a clock edge.
- Streaming: out_ready=1, push D=1..8 on consecutive cycles -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Backpressure: push 0xA, 0xB with out_ready=0 -> state TWO, in_ready=0, out_data=0xA held, stall_cnt increments per cycle. Raise out_ready -> 0xA then 0xB delivered in order, in_ready returns to 1 one cycle after the first pop.
- Flush in TWO with in_valid=1 (data 0xC) -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, 0xC never appears, in_ready=1.
- Simultaneous push & pop in ONE: main=0x5, push 0x6 with out_ready=1 -> 0x5 consumed, state stays ONE, out_data=0x6.
- Saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: stage state encoding,
// NOP control bundle and per-stage bundle widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stageState_t;

  // All-zero control bundle: no register, memory or PC side effects.
  localparam int          CTRL_NOP_W = 16;
  localparam logic [15:0] CTRL_NOP   = 16'h0000;

  localparam int ID_EX_DATA_W  = 128;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int EX_MEM_DATA_W = 72;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 4;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with enable; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count enabled cycles until the maximum value is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_W{1'b0}};
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer,
// flush squash, bubble-safe control output and a saturating stall counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = ID_EX_DATA_W,
  parameter int                CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  stageState_t       state;
  stageState_t       nextState;
  logic              inReadyQ;
  logic              outValidQ;
  logic [CTRL_W-1:0] outCtrlQ;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] nextMainData;
  logic [CTRL_W-1:0] nextMainCtrl;
  logic              loadMainIn;
  logic              loadMainSkid;
  logic              loadSkid;
  logic              push;
  logic              pop;

  assign push = in_valid & inReadyQ & ~flush;
  assign pop  = outValidQ & out_ready;

  // Next-state and buffer load selection; flush discards everything held.
  always_comb begin
    nextState    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            nextState  = ONE;
            loadMainIn = 1'b1;
          end else begin
            nextState = EMPTY;
          end
        end
        ONE: begin
          if (push && !pop) begin
            nextState = TWO;
            loadSkid  = 1'b1;
          end else if (push && pop) begin
            nextState  = ONE;
            loadMainIn = 1'b1;
          end else if (pop) begin
            nextState = EMPTY;
          end else begin
            nextState = ONE;
          end
        end
        TWO: begin
          if (pop) begin
            nextState    = ONE;
            loadMainSkid = 1'b1;
          end else begin
            nextState = TWO;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  // Head entry mux: new input, promoted skid entry, or hold.
  always_comb begin
    nextMainData = mainData;
    nextMainCtrl = mainCtrl;
    if (loadMainIn) begin
      nextMainData = in_data;
      nextMainCtrl = in_ctrl;
    end else if (loadMainSkid) begin
      nextMainData = skidData;
      nextMainCtrl = skidCtrl;
    end else begin
      nextMainData = mainData;
      nextMainCtrl = mainCtrl;
    end
  end

  // State, handshake flags and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
      outCtrlQ  <= CTRL_BUBBLE;
      mainData  <= {DATA_W{1'b0}};
      mainCtrl  <= CTRL_BUBBLE;
      skidData  <= {DATA_W{1'b0}};
      skidCtrl  <= CTRL_BUBBLE;
    end else begin
      state     <= nextState;
      inReadyQ  <= (nextState != TWO);
      outValidQ <= (nextState != EMPTY);
      // Control output is pre-muxed so an empty stage always shows a bubble.
      outCtrlQ  <= (nextState != EMPTY) ? nextMainCtrl : CTRL_BUBBLE;
      mainData  <= nextMainData;
      mainCtrl  <= nextMainCtrl;
      if (loadSkid) begin
        skidData <= in_data;
        skidCtrl <= in_ctrl;
      end
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign out_data  = mainData;
  assign out_ctrl  = outCtrlQ;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (outValidQ & ~out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: expected entries are queued as
// they are pushed and compared when the stage presents them.
module tb_pipe_stage_elastic;

  localparam int          DATA_W = 128;
  localparam int          CTRL_W = 16;
  localparam int          CNT_W  = 4;
  localparam logic [15:0] BUBBLE = 16'hA5C3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int passCnt = 0;
  int totalCnt = 0;

  logic [DATA_W-1:0] expData[$];
  logic [CTRL_W-1:0] expCtrl[$];

  pipe_stage_elastic #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (BUBBLE),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mkData(input logic [31:0] v);
    return {4{v}};
  endfunction

  function automatic logic [CTRL_W-1:0] mkCtrl(input logic [31:0] v);
    return v[15:0] ^ 16'h1200;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    expData.delete(); expCtrl.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic pushEntry(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = mkData(v);
    in_ctrl  = mkCtrl(v);
    expData.push_back(mkData(v));
    expCtrl.push_back(mkCtrl(v));
  endtask

  task automatic test_reset();
    doReset();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else passCnt++;
    totalCnt++; if (out_ctrl !== BUBBLE) $display("FAIL rst_out_ctrl: got %h want %h", out_ctrl, BUBBLE); else passCnt++;
    totalCnt++; if (out_data !== '0) $display("FAIL rst_out_data: got %h want 0", out_data); else passCnt++;
    // Fill both entries, then drop reset between clock edges.
    out_ready = 1'b0;
    pushEntry(32'h77); cyc();
    pushEntry(32'h78); cyc();
    in_valid = 1'b0;
    totalCnt++; if (in_ready !== 1'b0) $display("FAIL rst_pre_two: in_ready got %0b want 0", in_ready); else passCnt++;
    #2;
    rst_n = 1'b0;
    #1;
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL async_rst_valid: got %0b want 0", out_valid); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL async_rst_ready: got %0b want 1", in_ready); else passCnt++;
    totalCnt++; if (out_ctrl !== BUBBLE) $display("FAIL async_rst_ctrl: got %h want %h", out_ctrl, BUBBLE); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd0) $display("FAIL async_rst_cnt: got %0d want 0", stall_cnt); else passCnt++;
    totalCnt++; if (out_data !== '0) $display("FAIL async_rst_data: got %h want 0", out_data); else passCnt++;
    #2;
    rst_n = 1'b1;
    expData.delete(); expCtrl.delete();
    cyc();
  endtask

  task automatic test_streaming();
    doReset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      pushEntry(32'(i));
      cyc();
      totalCnt++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); else passCnt++;
      totalCnt++; if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %0b want 1", i, in_ready); else passCnt++;
      totalCnt++; if (out_data !== expData[0]) $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, expData[0]); else passCnt++;
      totalCnt++; if (out_ctrl !== expCtrl[0]) $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, expCtrl[0]); else passCnt++;
      void'(expData.pop_front()); void'(expCtrl.pop_front());
    end
    in_valid = 1'b0;
    cyc();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid: got %0b want 0", out_valid); else passCnt++;
    totalCnt++; if (out_ctrl !== BUBBLE) $display("FAIL stream_drain_ctrl: got %h want %h", out_ctrl, BUBBLE); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall: got %0d want 0", stall_cnt); else passCnt++;
  endtask

  task automatic test_backpressure();
    doReset();
    out_ready = 1'b0;
    pushEntry(32'hA); cyc();
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one: got %0b want 1", in_ready); else passCnt++;
    pushEntry(32'hB); cyc();
    in_valid = 1'b0;
    totalCnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready_two: got %0b want 0", in_ready); else passCnt++;
    totalCnt++; if (out_data !== expData[0]) $display("FAIL bp_head: got %h want %h", out_data, expData[0]); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd1) $display("FAIL bp_stall1: got %0d want 1", stall_cnt); else passCnt++;
    cyc(); cyc();
    totalCnt++; if (out_data !== expData[0]) $display("FAIL bp_hold_data: got %h want %h", out_data, expData[0]); else passCnt++;
    totalCnt++; if (out_ctrl !== expCtrl[0]) $display("FAIL bp_hold_ctrl: got %h want %h", out_ctrl, expCtrl[0]); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd3) $display("FAIL bp_stall3: got %0d want 3", stall_cnt); else passCnt++;
    out_ready = 1'b1;
    void'(expData.pop_front()); void'(expCtrl.pop_front());
    cyc();
    totalCnt++; if (out_data !== expData[0]) $display("FAIL bp_second: got %h want %h", out_data, expData[0]); else passCnt++;
    totalCnt++; if (out_ctrl !== expCtrl[0]) $display("FAIL bp_second_ctrl: got %h want %h", out_ctrl, expCtrl[0]); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back: got %0b want 1", in_ready); else passCnt++;
    totalCnt++; if (stall_cnt !== 4'd3) $display("FAIL bp_stall_keep: got %0d want 3", stall_cnt); else passCnt++;
    void'(expData.pop_front()); void'(expCtrl.pop_front());
    cyc();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty: got %0b want 0", out_valid); else passCnt++;
  endtask

  task automatic test_flush();
    doReset();
    out_ready = 1'b0;
    pushEntry(32'hA); cyc();
    pushEntry(32'hB); cyc();
    in_valid = 1'b1; in_data = mkData(32'hC); in_ctrl = mkCtrl(32'hC);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    expData.delete(); expCtrl.delete();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", out_valid); else passCnt++;
    totalCnt++; if (out_ctrl !== BUBBLE) $display("FAIL flush_ctrl: got %h want %h", out_ctrl, BUBBLE); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL flush_ready: got %0b want 1", in_ready); else passCnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      totalCnt++; if (out_valid !== 1'b0) $display("FAIL flush_no_c[%0d]: got %0b want 0", i, out_valid); else passCnt++;
    end
    // Flush while in ONE with an input offered: the input must be dropped.
    out_ready = 1'b0;
    pushEntry(32'h11); cyc();
    in_valid = 1'b1; in_data = mkData(32'h22); in_ctrl = mkCtrl(32'h22);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    expData.delete(); expCtrl.delete();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL flush_one_valid: got %0b want 0", out_valid); else passCnt++;
    cyc();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL flush_one_drop: got %0b want 0", out_valid); else passCnt++;
  endtask

  task automatic test_push_pop();
    doReset();
    out_ready = 1'b0;
    pushEntry(32'h5); cyc();
    totalCnt++; if (out_data !== expData[0]) $display("FAIL pp_first: got %h want %h", out_data, expData[0]); else passCnt++;
    out_ready = 1'b1;
    void'(expData.pop_front()); void'(expCtrl.pop_front());
    pushEntry(32'h6); cyc();
    in_valid = 1'b0;
    totalCnt++; if (out_valid !== 1'b1) $display("FAIL pp_valid: got %0b want 1", out_valid); else passCnt++;
    totalCnt++; if (out_data !== expData[0]) $display("FAIL pp_data: got %h want %h", out_data, expData[0]); else passCnt++;
    totalCnt++; if (out_ctrl !== expCtrl[0]) $display("FAIL pp_ctrl: got %h want %h", out_ctrl, expCtrl[0]); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL pp_ready: got %0b want 1", in_ready); else passCnt++;
    void'(expData.pop_front()); void'(expCtrl.pop_front());
    cyc();
    totalCnt++; if (out_valid !== 1'b0) $display("FAIL pp_empty: got %0b want 0", out_valid); else passCnt++;
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] want;
    doReset();
    out_ready = 1'b0;
    pushEntry(32'h99); cyc();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      want = (k > 15) ? 4'd15 : 4'(k);
      totalCnt++; if (stall_cnt !== want) $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, stall_cnt, want); else passCnt++;
    end
    totalCnt++; if (out_data !== expData[0]) $display("FAIL sat_hold: got %h want %h", out_data, expData[0]); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_saturation();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
